// File: rtl/wb_alarm_mon.sv
// wb_alarm_mon: multi-channel alarm monitor on the Wishbone bus.
// Each raw alarm input is synchronised and rising-edge detected. Enabled
// channels set a sticky latch (write-1-to-clear) and bump a saturating
// event counter. Latches gated by IRQ_MASK produce a registered interrupt.
module wb_alarm_mon #(
    parameter int          NUM_CH    = 4,
    parameter int          CTR_W     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_addr,
    input  logic [31:0]       i_wb_data,
    output logic              o_wb_ack,
    output logic              o_wb_stall,
    output logic [31:0]       o_wb_data,
    input  logic [NUM_CH-1:0] alarm_i,
    output logic [NUM_CH-1:0] ch_en_o,
    output logic              irq_o
);

    localparam logic [5:0]       IDX_CTRL   = 6'd0;
    localparam logic [5:0]       IDX_STATUS = 6'd1;
    localparam logic [5:0]       IDX_MASK   = 6'd2;
    localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};

    logic              accept;
    logic              sel;
    logic              wr;
    logic [5:0]        widx;
    logic [NUM_CH-1:0] sync_1;
    logic [NUM_CH-1:0] sync_s;
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] edge_det;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] latch;
    logic [NUM_CH-1:0] w1c;
    logic [NUM_CH-1:0] ctr_clr;
    logic [CTR_W-1:0]  ctr [NUM_CH];
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign accept     = i_wb_cyc & i_wb_stb;
    assign sel        = (i_wb_addr[31:8] == BASE_ADDR[31:8]);
    assign wr         = accept & sel & i_wb_we;
    assign widx       = i_wb_addr[7:2];
    assign edge_det   = sync_s & ~prev;
    assign hit        = edge_det & ch_en;
    assign o_wb_stall = 1'b0;
    assign ch_en_o    = ch_en;
    assign unused_bits = ^{i_wb_addr[1:0], i_wb_data};

    // Two-flop synchroniser followed by the previous-value register for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= '0;
            sync_s <= '0;
            prev   <= '0;
        end else begin
            sync_1 <= alarm_i;
            sync_s <= sync_1;
            prev   <= sync_s;
        end
    end

    // Per-channel write strobes: W1C mask for STATUS and clear pulses for CTR[n]
    always_comb begin
        w1c     = '0;
        ctr_clr = '0;
        if (wr && widx == IDX_STATUS)
            w1c = i_wb_data[NUM_CH-1:0];
        for (int n = 0; n < NUM_CH; n++) begin
            if (wr && int'(widx) == n + 4)
                ctr_clr[n] = 1'b1;
        end
    end

    // Configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_en <= '0;
            mask  <= '0;
        end else begin
            if (wr && widx == IDX_CTRL)
                ch_en <= i_wb_data[NUM_CH-1:0];
            if (wr && widx == IDX_MASK)
                mask <= i_wb_data[NUM_CH-1:0];
        end
    end

    // Sticky latches; a new qualifying edge beats a same-cycle W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            latch <= '0;
        else
            latch <= (latch & ~w1c) | hit;
    end

    // Saturating event counters; an edge during a clear leaves a count of one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_CH; n++)
                ctr[n] <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (hit[n]) begin
                    if (ctr_clr[n])
                        ctr[n] <= CTR_W'(1);
                    else if (ctr[n] != CTR_MAX)
                        ctr[n] <= ctr[n] + CTR_W'(1);
                end else if (ctr_clr[n]) begin
                    ctr[n] <= '0;
                end
            end
        end
    end

    // Read mux over the current register values; unselected or unmapped reads give 0
    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (widx)
                IDX_CTRL:   rd_data[NUM_CH-1:0] = ch_en;
                IDX_STATUS: begin
                    rd_data[NUM_CH-1:0]     = latch;
                    rd_data[16+NUM_CH-1:16] = sync_s;
                end
                IDX_MASK:   rd_data[NUM_CH-1:0] = mask;
                default: begin
                    for (int n = 0; n < NUM_CH; n++) begin
                        if (int'(widx) == n + 4)
                            rd_data[CTR_W-1:0] = ctr[n];
                    end
                end
            endcase
        end
    end

    // Bus response: one ack per accepted request, read data captured alongside it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= accept;
            if (accept && !i_wb_we)
                o_wb_data <= rd_data;
        end
    end

    // Registered interrupt from masked latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_o <= 1'b0;
        else
            irq_o <= |(latch & mask);
    end

endmodule

// File: tb/tb_wb_alarm_mon.sv
// Directed, self-checking bench for wb_alarm_mon with default parameters.
module tb_wb_alarm_mon;

    localparam int NUM_CH = 4;

    logic              clk;
    logic              reset;
    logic              i_wb_cyc;
    logic              i_wb_stb;
    logic              i_wb_we;
    logic [31:0]       i_wb_addr;
    logic [31:0]       i_wb_data;
    logic              o_wb_ack;
    logic              o_wb_stall;
    logic [31:0]       o_wb_data;
    logic [NUM_CH-1:0] alarm_i;
    logic [NUM_CH-1:0] ch_en_o;
    logic              irq_o;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_MASK   = 32'h3000_0008;
    localparam logic [31:0] A_CTR0   = 32'h3000_0010;
    localparam logic [31:0] A_UNSEL  = 32'h3000_0100;

    wb_alarm_mon #(.NUM_CH(4), .CTR_W(8), .BASE_ADDR(32'h3000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data),
        .alarm_i    (alarm_i),
        .ch_en_o    (ch_en_o),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [20];
    int   nvec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request now (caller is just past a rising edge), samples after the next edge.
    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic ack, output logic [31:0] rdata);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = wdata;
        @(posedge clk);
        #1;
        ack   = o_wb_ack;
        rdata = o_wb_data;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic        a;
        logic [31:0] d;
        bus_op(1'b1, addr, data, a, d);
        check("wr_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic        a;
        logic [31:0] d;
        bus_op(1'b0, addr, 32'd0, a, d);
        check({name, "_ack"}, {31'd0, a}, 32'd1);
        check(name, d, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse one channel: high for hi sampled edges, then low for lo sampled edges.
    task automatic pulse(input int ch, input int hi, input int lo);
        alarm_i[ch] = 1'b1;
        tick(hi);
        alarm_i[ch] = 1'b0;
        tick(lo);
    endtask

    initial begin
        logic        a;
        logic [31:0] d;
        logic        seen_ack;

        reset     = 1'b1;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_addr = '0;
        i_wb_data = '0;
        alarm_i   = '0;

        tick(10);
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("rst_data", o_wb_data, 32'd0);
        check("rst_chen", {28'd0, ch_en_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);

        nvec = 0;
        vecs[nvec++] = '{1'b0, A_CTRL,        32'h0,        32'h0, "rd_ctrl0"};
        vecs[nvec++] = '{1'b0, A_STATUS,      32'h0,        32'h0, "rd_status0"};
        vecs[nvec++] = '{1'b0, A_MASK,        32'h0,        32'h0, "rd_mask0"};
        vecs[nvec++] = '{1'b0, 32'h3000_0010, 32'h0,        32'h0, "rd_ctr0_0"};
        vecs[nvec++] = '{1'b0, 32'h3000_0014, 32'h0,        32'h0, "rd_ctr1_0"};
        vecs[nvec++] = '{1'b0, 32'h3000_0018, 32'h0,        32'h0, "rd_ctr2_0"};
        vecs[nvec++] = '{1'b0, 32'h3000_001C, 32'h0,        32'h0, "rd_ctr3_0"};
        vecs[nvec++] = '{1'b1, A_CTRL,        32'hFFFF_FFFF, 32'h0, "wr_ctrl_all"};
        vecs[nvec++] = '{1'b0, A_CTRL,        32'h0,        32'hF, "rd_ctrl_f"};
        vecs[nvec++] = '{1'b1, A_MASK,        32'h0000_0005, 32'h0, "wr_mask5"};
        vecs[nvec++] = '{1'b0, A_MASK,        32'h0,        32'h5, "rd_mask5"};
        vecs[nvec++] = '{1'b0, 32'h3000_000C, 32'h0,        32'h0, "rd_unmapped_0c"};
        vecs[nvec++] = '{1'b0, 32'h3000_0020, 32'h0,        32'h0, "rd_unmapped_20"};
        vecs[nvec++] = '{1'b1, A_UNSEL,       32'h0,        32'h0, "wr_unsel"};
        vecs[nvec++] = '{1'b0, A_UNSEL,       32'h0,        32'h0, "rd_unsel"};
        vecs[nvec++] = '{1'b0, A_CTRL,        32'h0,        32'hF, "rd_ctrl_kept"};
        vecs[nvec++] = '{1'b1, A_CTRL,        32'h0,        32'h0, "wr_ctrl0"};
        vecs[nvec++] = '{1'b1, A_MASK,        32'h0,        32'h0, "wr_mask0"};
        vecs[nvec++] = '{1'b0, A_MASK,        32'h0,        32'h0, "rd_mask_cleared"};
        vecs[nvec++] = '{1'b0, A_CTRL,        32'h0,        32'h0, "rd_ctrl_cleared"};

        for (int i = 0; i < nvec; i++) begin
            bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, a, d);
            check({vecs[i].name, "_ack"}, {31'd0, a}, 32'd1);
            if (!vecs[i].we)
                check(vecs[i].name, d, vecs[i].exp);
        end

        // Single edge on ch0 with latency of irq
        wr(A_CTRL, 32'h1);
        check("chen_1", {28'd0, ch_en_o}, 32'h1);
        wr(A_MASK, 32'h1);
        alarm_i[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("irq_lat_%0d", i), {31'd0, irq_o}, (i == 3) ? 32'd1 : 32'd0);
            if (i == 2)
                alarm_i[0] = 1'b0;
        end
        tick(3);
        rd("status_single", A_STATUS, 32'h0000_0001);
        rd("ctr0_single", A_CTR0, 32'd1);
        wr(A_STATUS, 32'h1);
        check("irq_hold_w1c", {31'd0, irq_o}, 32'd1);
        tick(1);
        check("irq_drop_w1c", {31'd0, irq_o}, 32'd0);

        // Enable gating on ch1
        for (int i = 0; i < 5; i++) pulse(1, 2, 3);
        rd("ctr1_gated", 32'h3000_0014, 32'd0);
        rd("status_gated", A_STATUS, 32'h0);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 5; i++) pulse(1, 2, 3);
        rd("ctr1_enabled", 32'h3000_0014, 32'd5);
        rd("status_ch1", A_STATUS, 32'h2);
        wr(A_STATUS, 32'h2);
        check("irq_unmasked_ch1", {31'd0, irq_o}, 32'd0);

        // Saturation on ch0 (already counted 1)
        for (int i = 0; i < 300; i++) pulse(0, 1, 1);
        tick(3);
        rd("ctr0_sat", A_CTR0, 32'd255);
        wr(A_CTR0, 32'h0);
        rd("ctr0_cleared", A_CTR0, 32'd0);
        wr(A_STATUS, 32'h3);
        tick(1);
        rd("status_cleared", A_STATUS, 32'h0);

        // Collision: W1C of latch[2] on the edge-detect cycle
        wr(A_CTRL, 32'h7);
        alarm_i[2] = 1'b1;
        tick(2);
        wr(A_STATUS, 32'h4);
        alarm_i[2] = 1'b0;
        tick(3);
        rd("latch2_set_wins", A_STATUS, 32'h4);
        rd("ctr2_first", 32'h3000_0018, 32'd1);

        // Collision: CTR[2] clear on the edge-detect cycle
        alarm_i[2] = 1'b1;
        tick(2);
        wr(32'h3000_0018, 32'h0);
        alarm_i[2] = 1'b0;
        tick(3);
        rd("ctr2_clear_edge", 32'h3000_0018, 32'd1);

        // Back-to-back reads: CTRL, STATUS, unselected
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_addr = A_CTRL;
        tick(1);
        check("b2b_ack0", {31'd0, o_wb_ack}, 32'd1);
        check("b2b_data0", o_wb_data, 32'h7);
        i_wb_addr = A_STATUS;
        tick(1);
        check("b2b_ack1", {31'd0, o_wb_ack}, 32'd1);
        check("b2b_data1", o_wb_data, 32'h4);
        i_wb_addr = A_UNSEL;
        tick(1);
        check("b2b_ack2", {31'd0, o_wb_ack}, 32'd1);
        check("b2b_data2", o_wb_data, 32'h0);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        tick(1);
        check("b2b_ack_end", {31'd0, o_wb_ack}, 32'd0);
        check("b2b_data_hold", o_wb_data, 32'h0);
        check("chen_7", {28'd0, ch_en_o}, 32'h7);

        // Reset arriving before the ack edge of a pending read
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_addr = A_CTRL;
        seen_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen_ack = seen_ack | o_wb_ack;
        @(posedge clk);
        #1;
        seen_ack = seen_ack | o_wb_ack;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        seen_ack = seen_ack | o_wb_ack;
        check("rst_mid_no_ack", {31'd0, seen_ack}, 32'd0);
        check("rst_mid_chen", {28'd0, ch_en_o}, 32'd0);
        check("rst_mid_irq", {31'd0, irq_o}, 32'd0);
        rd("rst_mid_ctrl", A_CTRL, 32'h0);
        rd("rst_mid_ctr2", 32'h3000_0018, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_alarm_mon.md
# wb_alarm_mon

Multi-channel alarm monitor on the Wishbone bus: the parametrised successor to the single-channel glitch/alarm peripheral. It synchronises NUM_CH raw alarm inputs and detects rising edges on enabled channels. Per channel it keeps a sticky latch (write-1-to-clear) and a saturating event counter, and it raises a maskable interrupt. Sits on the system Wishbone bus at BASE_ADDR beside the GPIO/alarm hardware.

## Interface
- NUM_CH, 4, number of alarm channels, legal 1..16
- CTR_W, 8, per-channel counter width, legal 1..32
- BASE_ADDR, 32'h3000_0000, block base; bits [7:0] must be 0
- clk  in  1  system clock
- reset  in  1  reset. One clock; reset is asynchronous and active-high.
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  32  byte address
- i_wb_data  in  32  write data
- o_wb_ack  out  1  request completed
- o_wb_stall  out  1  always 0
- o_wb_data  out  32  read data
- alarm_i  in  NUM_CH  raw alarm inputs, asynchronous to clk
- ch_en_o  out  NUM_CH  channel enables, mirror CTRL[NUM_CH-1:0]
- irq_o  out  1  registered interrupt

## Operation
- Request accepted on any edge with i_wb_cyc & i_wb_stb. The block is selected when i_wb_addr[31:8] == BASE_ADDR[31:8]; word index = i_wb_addr[7:2].
- Register map, by byte offset:
  - 0x00 CTRL, RW: [NUM_CH-1:0] ch_en.
  - 0x04 STATUS: [NUM_CH-1:0] latch, W1C; [16+NUM_CH-1:16] live synchronised alarm, RO.
  - 0x08 IRQ_MASK, RW: [NUM_CH-1:0].
  - 0x10+4*n CTR[n] for n < NUM_CH: [CTR_W-1:0] count, RO. Any write clears it.
- Unimplemented bits and unmapped offsets read 0; writes to them are ignored.
- Per channel n:
  - alarm_i[n] passes through a 2-FF synchroniser to give s[n], then a previous-value register p[n]; edge[n] = s[n] & ~p[n].
  - edge[n] & ch_en[n] sets latch[n] and increments CTR[n].
  - CTR[n] saturates at 2^CTR_W-1 and never wraps.
  - A disabled channel ignores edges; its latch and counter keep their values.
- irq_o is registered: irq_o = |(latch & IRQ_MASK).
- Simultaneous events:
  - W1C of latch[n] in the same cycle as a qualifying edge: the latch stays 1 (set wins).
  - Clear write to CTR[n] in the same cycle as a qualifying edge: CTR[n] becomes 1.
  - Same-cycle edges on several channels are each counted independently.
- Reset:
  - Clears CTRL, IRQ_MASK, all latches, all counters, the synchronisers and p.
  - Outputs during and after reset: o_wb_ack=0, o_wb_data=0, ch_en_o=0, irq_o=0.
  - Reset mid-transaction drops the pending ack.

## Timing
- o_wb_ack pulses exactly one cycle, on the edge after acceptance. It is acked for every accepted request, selected or not. o_wb_stall is tied to 0, so back-to-back requests each receive one ack.
- o_wb_data is registered and updates on the ack edge. It carries register values as they stood before that acceptance edge, and holds until the next read ack. Writes do not change o_wb_data.
- Write effects are visible from the ack edge. ch_en_o changes on the same edge as the CTRL register.
- alarm_i rising, first sampled high at edge k: s high after k+1, latch and CTR updated at edge k+2, irq_o at edge k+3.
- A W1C latch clear or a mask write drops irq_o one edge after the register update.
- Pulses on alarm_i shorter than one clock period may be missed. A level held high counts once; the next count needs a low of at least one sampled clock.

## Test plan
- Reset: hold reset 10 cycles, then read all registers → every read returns 0; ch_en_o=0, irq_o=0, o_wb_ack pulses once per request.
- Single edge: write CTRL=0x1 and IRQ_MASK=0x1, then pulse alarm_i[0] high for 3 cycles.
  - STATUS=0x0000_0001 while the pulse is low again; CTR[0]=1.
  - irq_o=1 exactly 3 edges after first sample.
  - Write STATUS=0x1 → latch clears, irq_o=0.
- Enable gating: CTRL=0x1, pulse alarm_i[1] five times → CTR[1]=0, STATUS[1]=0. Then set CTRL=0x3 and pulse 5 more times → CTR[1]=5.
- Saturation: CTR_W=8, CTRL=0x1, 300 pulses on ch0 → CTR[0]=255. A write to 0x10 → CTR[0]=0.
- Collisions:
  - W1C of latch[2] on the exact edge-detect cycle → latch[2] remains 1.
  - CTR[2] clear on the edge-detect cycle → CTR[2]=1.
- Bus: back-to-back reads of 0x00, 0x04, 0x3000_0100 (unselected) → three one-cycle acks, last data 0. Assert reset between acceptance and ack → no ack is produced.
